// File: rtl/wb_ram_bridge.sv
// Wishbone classic slave sharing one single-port RAM with the core memory port.
// Core has priority; a Wishbone request blocked STARVE_LIMIT cycles is forced through.
module wb_ram_bridge #(
    parameter int ADDR_WIDTH   = 11,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_dat_i,
    input  logic [31:0]           wbs_adr_i,
    output logic                  wbs_ack_o,
    output logic [31:0]           wbs_dat_o,
    input  logic                  core_req_i,
    input  logic                  core_we_i,
    input  logic [3:0]            core_be_i,
    input  logic [ADDR_WIDTH-1:0] core_addr_i,
    input  logic [31:0]           core_wdata_i,
    output logic                  core_gnt_o,
    output logic                  core_rvalid_o,
    output logic [31:0]           core_rdata_o,
    output logic                  ram_csb_o,
    output logic                  ram_web_o,
    output logic [3:0]            ram_wmask_o,
    output logic [ADDR_WIDTH-3:0] ram_addr_o,
    output logic [31:0]           ram_din_o,
    input  logic [31:0]           ram_dout_i
);

    typedef enum logic {IDLE, WB_WAIT} state_t;

    state_t     state_q, state_d;
    logic [7:0] starve_cnt_q, starve_cnt_d;
    logic       wb_we_q, wb_we_d;
    logic       core_rvalid_q, core_rvalid_d;

    logic       wb_req;
    logic       force_wb;
    logic       core_sel;
    logic       wb_issue;

    // Upper address bits were decoded by the mux; low bits are byte offsets.
    logic       unused_addr_bits;
    assign unused_addr_bits = ^{wbs_adr_i[31:ADDR_WIDTH], wbs_adr_i[1:0], core_addr_i[1:0]};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q       <= IDLE;
            starve_cnt_q  <= 8'd0;
            wb_we_q       <= 1'b0;
            core_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_cnt_q  <= starve_cnt_d;
            wb_we_q       <= wb_we_d;
            core_rvalid_q <= core_rvalid_d;
        end
    end

    // Arbitration; all RAM-facing decisions are masked while reset is held
    // so nothing reaches the macro mid-reset.
    always_comb begin
        wb_req   = wbs_stb_i & wbs_cyc_i & (state_q == IDLE) & ~wb_rst_i;
        force_wb = wb_req & (starve_cnt_q >= 8'(STARVE_LIMIT));
        core_sel = core_req_i & ~force_wb & ~wb_rst_i;
        wb_issue = wb_req & ~core_sel;
    end

    always_comb begin
        state_d       = IDLE;
        wb_we_d       = wb_we_q;
        starve_cnt_d  = starve_cnt_q;
        core_rvalid_d = core_sel & ~core_we_i;

        if (wb_issue) begin
            state_d = WB_WAIT;
            wb_we_d = wbs_we_i;
        end

        if (!wb_req || wb_issue) begin
            starve_cnt_d = 8'd0;
        end else if (starve_cnt_q != 8'hFF) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end
    end

    always_comb begin
        ram_csb_o   = 1'b1;
        ram_web_o   = 1'b1;
        ram_wmask_o = 4'h0;
        ram_addr_o  = '0;
        ram_din_o   = 32'h0;

        if (core_sel) begin
            ram_csb_o   = 1'b0;
            ram_web_o   = ~core_we_i;
            ram_wmask_o = core_be_i;
            ram_addr_o  = core_addr_i[ADDR_WIDTH-1:2];
            ram_din_o   = core_wdata_i;
        end else if (wb_issue) begin
            ram_csb_o   = 1'b0;
            ram_web_o   = ~wbs_we_i;
            ram_wmask_o = wbs_sel_i;
            ram_addr_o  = wbs_adr_i[ADDR_WIDTH-1:2];
            ram_din_o   = wbs_dat_i;
        end
    end

    always_comb begin
        wbs_ack_o = (state_q == WB_WAIT);
        wbs_dat_o = (wbs_ack_o && !wb_we_q) ? ram_dout_i : 32'h0;
    end

    assign core_gnt_o    = core_sel;
    assign core_rvalid_o = core_rvalid_q;
    assign core_rdata_o  = ram_dout_i;

endmodule

// File: tb/tb_wb_ram_bridge.sv
// Directed self-checking bench for wb_ram_bridge with a behavioural single-port RAM.
module tb_wb_ram_bridge;

    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          stb, cyc, we;
    logic [3:0]    sel;
    logic [31:0]   wdat, adr;
    logic          ack;
    logic [31:0]   rdat;
    logic          core_req, core_we;
    logic [3:0]    core_be;
    logic [AW-1:0] core_addr;
    logic [31:0]   core_wdata;
    logic          core_gnt, core_rvalid;
    logic [31:0]   core_rdata;
    logic          csb, web;
    logic [3:0]    wmask;
    logic [AW-3:0] raddr;
    logic [31:0]   din, dout;

    logic [31:0]   mem [0:(1<<(AW-2))-1];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    wb_ram_bridge #(.ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_dat_i(wdat), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .core_req_i(core_req), .core_we_i(core_we), .core_be_i(core_be),
        .core_addr_i(core_addr), .core_wdata_i(core_wdata),
        .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
        .ram_csb_o(csb), .ram_web_o(web), .ram_wmask_o(wmask),
        .ram_addr_o(raddr), .ram_din_o(din), .ram_dout_i(dout)
    );

    // OpenRAM-style macro: masked write or registered read on an enabled edge.
    always @(posedge clk) begin
        if (!csb) begin
            if (!web) begin
                for (int b = 0; b < 4; b++)
                    if (wmask[b]) mem[raddr][b*8 +: 8] <= din[b*8 +: 8];
            end else begin
                dout <= mem[raddr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One Wishbone transfer with the core idle; returns read data, the issued
    // word address/mask and issue-to-ack distance (-1 if ack never came).
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, output logic [31:0] rd,
                           output logic [31:0] iss_addr, output logic [31:0] iss_mask,
                           output int lat);
        int iss_cyc;
        iss_cyc  = -1;
        lat      = -1;
        rd       = 32'hx;
        iss_addr = 32'hx;
        iss_mask = 32'hx;
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; sel = s; wdat = d;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (!csb && !ack && iss_cyc < 0) begin
                iss_cyc  = i;
                iss_addr = 32'(raddr);
                iss_mask = 32'(wmask);
            end
            if (ack) begin
                rd  = rdat;
                lat = (iss_cyc < 0) ? -1 : i - iss_cyc;
                break;
            end
            tick();
            #1;
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        tick();
    endtask

    logic [31:0] rd, ia, im;
    int          lat;

    initial begin
        rst = 1'b1; stb = 0; cyc = 0; we = 0; sel = 0; wdat = 0; adr = 0;
        core_req = 1'b1; core_we = 0; core_be = 4'hF; core_addr = '0; core_wdata = 0;
        tick(); tick();
        #1;
        check("rst_ack",    32'(ack), 0);
        check("rst_dat",    rdat, 0);
        check("rst_rvalid", 32'(core_rvalid), 0);
        check("rst_gnt",    32'(core_gnt), 0);
        check("rst_csb",    32'(csb), 1);
        check("rst_web",    32'(web), 1);
        check("rst_wmask",  32'(wmask), 0);
        core_req = 1'b0;
        rst = 1'b0;
        tick();

        // full-word write then read at byte address 0x10 -> word 4
        wb_xfer(1, 32'h3000_0010, 4'hF, 32'hDEAD_BEEF, rd, ia, im, lat);
        check("wr_addr", ia, 4);
        check("wr_mask", im, 32'hF);
        check("wr_lat",  32'(lat), 1);
        check("wr_dat0", rd, 0);
        wb_xfer(0, 32'h3000_0010, 4'hF, 32'h0, rd, ia, im, lat);
        check("rd_addr", ia, 4);
        check("rd_lat",  32'(lat), 1);
        check("rd_data", rd, 32'hDEAD_BEEF);

        // byte-lane write over 0x11223344
        wb_xfer(1, 32'h3000_0020, 4'hF, 32'h1122_3344, rd, ia, im, lat);
        wb_xfer(1, 32'h3000_0020, 4'b0100, 32'h00AB_0000, rd, ia, im, lat);
        check("byte_mask", im, 32'h4);
        wb_xfer(0, 32'h3000_0020, 4'hF, 32'h0, rd, ia, im, lat);
        check("byte_rd", rd, 32'h11AB_3344);

        // preload words 2 and 5 for the core tests
        wb_xfer(1, 32'h3000_0008, 4'hF, 32'hCAFE_F00D, rd, ia, im, lat);
        wb_xfer(1, 32'h3000_0014, 4'hF, 32'h5555_AAAA, rd, ia, im, lat);

        // back-to-back core reads of 0x8
        core_req = 1'b1; core_we = 1'b0; core_addr = 11'h008;
        #1;
        check("cr_gnt0",    32'(core_gnt), 1);
        check("cr_rv0",     32'(core_rvalid), 0);
        check("cr_raddr",   32'(raddr), 2);
        for (int c = 0; c < 2; c++) begin
            tick();
            #1;
            check("cr_gnt",   32'(core_gnt), 1);
            check("cr_rv",    32'(core_rvalid), 1);
            check("cr_rdata", core_rdata, 32'hCAFE_F00D);
        end
        core_req = 1'b0;
        #1;
        check("cr_gnt_off", 32'(core_gnt), 0);
        check("cr_rv_tail", 32'(core_rvalid), 1);
        tick();
        #1;
        check("cr_rv_end",  32'(core_rvalid), 0);

        // starvation: core holds req, WB read of word 5 forced through in cycle 5
        core_req = 1'b1; core_addr = 11'h008;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_0014;
        for (int c = 1; c <= 4; c++) begin
            #1;
            check("stv_gnt", 32'(core_gnt), 1);
            check("stv_ack", 32'(ack), 0);
            tick();
        end
        #1;
        check("stv_force_gnt", 32'(core_gnt), 0);
        check("stv_force_csb", 32'(csb), 0);
        check("stv_force_adr", 32'(raddr), 5);
        check("stv_force_web", 32'(web), 1);
        tick();
        #1;
        check("wait_ack",    32'(ack), 1);
        check("wait_dat",    rdat, 32'h5555_AAAA);
        check("wait_gnt",    32'(core_gnt), 1);
        check("wait_rv",     32'(core_rvalid), 0);
        stb = 1'b0; cyc = 1'b0;
        tick();
        #1;
        check("post_rv",    32'(core_rvalid), 1);
        check("post_rdata", core_rdata, 32'hCAFE_F00D);
        check("post_ack",   32'(ack), 0);
        check("post_dat",   rdat, 0);
        core_req = 1'b0;
        tick();

        // reset lands on the cycle a WB write issues
        wb_xfer(1, 32'h3000_0024, 4'hF, 32'h1234_5678, rd, ia, im, lat);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h3000_0024; wdat = 32'h9999_9999;
        #1;
        check("rsti_csb0", 32'(csb), 0);
        rst = 1'b1;
        #1;
        check("rsti_csb1", 32'(csb), 1);
        check("rsti_ack0", 32'(ack), 0);
        tick();
        #1;
        check("rsti_ack1", 32'(ack), 0);
        rst = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0;
        tick();
        wb_xfer(0, 32'h3000_0024, 4'hF, 32'h0, rd, ia, im, lat);
        check("rsti_lat",  32'(lat), 1);
        check("rsti_data", rd, 32'h1234_5678);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
